// File: rtl/parity_frame_chk_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// parity_frame_chk_pkg : state encodings and sizing helper for parity_frame_chk
// Revision: 1.0
// ---------------------------------------------------------------------------
package parity_frame_chk_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_PAR  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // One spare bit above the index width keeps the counter expression simple.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xor2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xor2 : two-input XOR cell, used as the parity accumulator
// Revision: 1.0
// ---------------------------------------------------------------------------
module xor2 (
  input  logic A,
  input  logic B,
  output logic C
);

  assign C = A ^ B;

endmodule
`default_nettype wire

// File: rtl/parity_frame_chk.sv
`default_nettype none
// ---------------------------------------------------------------------------
// parity_frame_chk : bit-serial frame receiver, LSB-first data plus one parity bit
// Revision: 1.0
// ---------------------------------------------------------------------------
module parity_frame_chk
  import parity_frame_chk_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ODD    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_ok,
  output logic              done,
  output logic              err_abort
);

  localparam int   CNT_W   = cnt_width(DATA_W);
  localparam logic ODD_BIT = (ODD != 0);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  state_t            state;
  logic              acc;
  logic              acc_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] data_next;

  xor2 u_acc_xor (
    .A (acc),
    .B (bit_in),
    .C (acc_next)
  );

  // First bit of a frame starts from a clean word; later bits patch one position.
  always_comb begin
    data_next = (cnt == '0) ? '0 : data_out;
    for (int i = 0; i < DATA_W; i++) begin
      if (cnt == CNT_W'(i)) begin
        data_next[i] = bit_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= 1'b0;
      cnt       <= '0;
      data_out  <= '0;
      parity_ok <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      done      <= 1'b0;
      err_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_DATA;
            acc   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_DATA: begin
          if (start) begin
            err_abort <= 1'b1;
            acc       <= 1'b0;
            cnt       <= '0;
          end else if (bit_valid) begin
            acc      <= acc_next;
            data_out <= data_next;
            cnt      <= cnt + CNT_W'(1);
            if (cnt == LAST_IDX) begin
              state <= ST_PAR;
            end
          end
        end
        ST_PAR: begin
          if (start) begin
            err_abort <= 1'b1;
            acc       <= 1'b0;
            cnt       <= '0;
            state     <= ST_DATA;
          end else if (bit_valid) begin
            parity_ok <= (acc_next == ODD_BIT);
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (start) begin
            state <= ST_DATA;
            acc   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_chk.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_parity_frame_chk : directed bench for even (ODD=0) and odd (ODD=1) builds
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_parity_frame_chk;

  logic       clk;
  logic       rst;
  logic       start;
  logic       bit_in;
  logic       bit_valid;

  logic       ev_busy, ev_parity_ok, ev_done, ev_err_abort;
  logic [7:0] ev_data_out;
  logic       od_busy, od_parity_ok, od_done, od_err_abort;
  logic [7:0] od_data_out;

  int n_cmp;
  int n_bad;

  parity_frame_chk #(.DATA_W(8), .ODD(0)) u_dut_even (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .busy      (ev_busy),
    .data_out  (ev_data_out),
    .parity_ok (ev_parity_ok),
    .done      (ev_done),
    .err_abort (ev_err_abort)
  );

  parity_frame_chk #(.DATA_W(8), .ODD(1)) u_dut_odd (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .busy      (od_busy),
    .data_out  (od_data_out),
    .parity_ok (od_parity_ok),
    .done      (od_done),
    .err_abort (od_err_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] d, input int gap);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      repeat (gap) tick();
    end
  endtask

  // After this returns the bench sits in the DONE cycle.
  task automatic send_frame(input logic [7:0] d, input logic par, input int gap);
    send_data(d, gap);
    send_bit(par);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(ev_busy), 32'd0);
    check("rst_data", 32'(ev_data_out), 32'h00);
    check("rst_pok", 32'(ev_parity_ok), 32'd0);
    check("rst_done", 32'(ev_done), 32'd0);
    check("rst_abort", 32'(ev_err_abort), 32'd0);
    rst = 1'b0;
    tick();

    // Good even frame 0xA5, parity 0 (four ones -> even).
    pulse_start();
    check("a5_busy", 32'(ev_busy), 32'd1);
    send_frame(8'hA5, 1'b0, 0);
    check("a5_done", 32'(ev_done), 32'd1);
    check("a5_data", 32'(ev_data_out), 32'hA5);
    check("a5_pok", 32'(ev_parity_ok), 32'd1);
    check("a5_busy_off", 32'(ev_busy), 32'd0);
    check("a5_odd_pok", 32'(od_parity_ok), 32'd0);
    tick();
    check("a5_done_pulse", 32'(ev_done), 32'd0);

    // Same frame with a wrong parity bit.
    pulse_start();
    send_frame(8'hA5, 1'b1, 0);
    check("bad_done", 32'(ev_done), 32'd1);
    check("bad_data", 32'(ev_data_out), 32'hA5);
    check("bad_pok", 32'(ev_parity_ok), 32'd0);
    check("bad_odd_pok", 32'(od_parity_ok), 32'd1);
    tick();

    // Asynchronous reset in the middle of a frame, after a good result.
    pulse_start();
    send_frame(8'hA5, 1'b0, 0);
    tick();
    pulse_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("mid_busy", 32'(ev_busy), 32'd1);
    check("mid_data", 32'(ev_data_out), 32'h05);
    check("mid_pok", 32'(ev_parity_ok), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(ev_busy), 32'd0);
    check("arst_data", 32'(ev_data_out), 32'h00);
    check("arst_pok", 32'(ev_parity_ok), 32'd0);
    #1;
    rst = 1'b0;
    tick();

    // 0x01 with three idle cycles between every bit, parity 1.
    pulse_start();
    send_data(8'h01, 3);
    send_bit(1'b1);
    check("gap_done", 32'(ev_done), 32'd1);
    check("gap_data", 32'(ev_data_out), 32'h01);
    check("gap_pok", 32'(ev_parity_ok), 32'd1);

    // Start in the DONE cycle: straight back into DATA.
    pulse_start();
    check("b2b_busy", 32'(ev_busy), 32'd1);
    check("b2b_done_low", 32'(ev_done), 32'd0);
    send_frame(8'hFF, 1'b0, 0);
    check("b2b_done", 32'(ev_done), 32'd1);
    check("b2b_data", 32'(ev_data_out), 32'hFF);
    check("b2b_pok", 32'(ev_parity_ok), 32'd1);
    tick();

    // Abort after four data bits; the restart cycle also carries a bit that must be dropped.
    pulse_start();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    check("abort_pulse", 32'(ev_err_abort), 32'd1);
    check("abort_no_done", 32'(ev_done), 32'd0);
    check("abort_busy", 32'(ev_busy), 32'd1);
    check("abort_pok_kept", 32'(ev_parity_ok), 32'd1);
    tick();
    check("abort_pulse_end", 32'(ev_err_abort), 32'd0);
    send_frame(8'h3C, 1'b0, 0);
    check("abort_re_done", 32'(ev_done), 32'd1);
    check("abort_re_data", 32'(ev_data_out), 32'h3C);
    check("abort_re_pok", 32'(ev_parity_ok), 32'd1);
    tick();

    // Start with a valid bit in IDLE: the bit is not taken as data.
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    send_frame(8'h80, 1'b1, 0);
    check("sv_done", 32'(ev_done), 32'd1);
    check("sv_data", 32'(ev_data_out), 32'h80);
    check("sv_pok", 32'(ev_parity_ok), 32'd1);
    tick();

    // Odd-parity build: 0x00 needs a parity bit of 1.
    pulse_start();
    send_frame(8'h00, 1'b1, 0);
    check("odd1_done", 32'(od_done), 32'd1);
    check("odd1_data", 32'(od_data_out), 32'h00);
    check("odd1_pok", 32'(od_parity_ok), 32'd1);
    check("odd1_even_pok", 32'(ev_parity_ok), 32'd0);
    tick();
    pulse_start();
    send_frame(8'h00, 1'b0, 0);
    check("odd0_done", 32'(od_done), 32'd1);
    check("odd0_pok", 32'(od_parity_ok), 32'd0);
    check("odd0_even_pok", 32'(ev_parity_ok), 32'd1);
    tick();
    check("idle_busy", 32'(ev_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
